// File: rtl/port_wr_enqueue.sv
// port_wr_enqueue: per-port priority queue occupancy keeper with dispatcher update handshake
module port_wr_enqueue #(
    parameter int CNT_W   = 8,
    parameter int UPD_GAP = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq_valid,
    input  logic [2:0]       enq_prior,
    output logic             enq_ready,
    input  logic             deq_valid,
    input  logic [3:0]       deq_prior,
    output logic             deq_ready,
    output logic [7:0]       queue_empty,
    output logic [7:0]       queue_full,
    output logic             update,
    output logic [CNT_W+2:0] total_cnt,
    output logic             err
);
    localparam int TW = CNT_W + 3;
    localparam int HW = UPD_GAP > 2 ? $clog2(UPD_GAP) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(UPD_GAP > 1 ? UPD_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, UPD, HOLD} state_t;

    state_t           state, state_nxt;
    logic [HW-1:0]    hold, hold_nxt;
    logic [CNT_W-1:0] cnt [8];
    logic [7:0]       inc, dec;
    logic             enq_acc, deq_acc, deq_ok;

    // occupancy flags come straight from the counters
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            queue_empty[i] = cnt[i] == '0;
            queue_full[i]  = &cnt[i];
        end
    end

    assign enq_ready = ~queue_full[enq_prior];
    assign enq_acc   = enq_valid & enq_ready;
    assign deq_ready = state == IDLE;
    assign update    = state == UPD;
    assign deq_acc   = deq_valid & deq_ready;
    // a retirement of "none" or of an empty queue is consumed but changes nothing
    assign deq_ok    = deq_acc & ~deq_prior[3] & ~queue_empty[deq_prior[2:0]];
    assign inc       = {7'b0, enq_acc} << enq_prior;
    assign dec       = {7'b0, deq_ok} << deq_prior[2:0];

    // per-queue counters; an enqueue and a dequeue on the same queue cancel
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (!rst_n)
                cnt[i] <= '0;
            else if (inc[i] && !dec[i])
                cnt[i] <= cnt[i] + CNT_W'(1);
            else if (dec[i] && !inc[i])
                cnt[i] <= cnt[i] - CNT_W'(1);
        end
    end

    // running total tracks the counter sum; err latches any illegal retirement
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (enq_acc && !deq_ok)
                total_cnt <= total_cnt + TW'(1);
            else if (deq_ok && !enq_acc)
                total_cnt <= total_cnt - TW'(1);
            if (deq_acc && !deq_ok)
                err <= 1'b1;
        end
    end

    // handshake FSM state and hold-off counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    // pulse update once per legal retirement, then hold off further retirements
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        case (state)
            IDLE: if (deq_ok) state_nxt = UPD;
            UPD: begin
                hold_nxt  = HOLD_LOAD;
                state_nxt = UPD_GAP > 1 ? HOLD : IDLE;
            end
            HOLD: begin
                hold_nxt = hold - HW'(1);
                if (hold <= HW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_port_wr_enqueue.sv
// tb_port_wr_enqueue: random and directed checks of port_wr_enqueue against a cycle-time model
module tb_port_wr_enqueue;
    localparam int CNT_W = 2;
    localparam int GAP   = 6;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enq_valid = 1'b0;
    logic [2:0]       enq_prior = '0;
    logic             enq_ready;
    logic             deq_valid = 1'b0;
    logic [3:0]       deq_prior = 4'd8;
    logic             deq_ready;
    logic [7:0]       queue_empty;
    logic [7:0]       queue_full;
    logic             update;
    logic [CNT_W+2:0] total_cnt;
    logic             err;

    int checks = 0;
    int passes = 0;

    int m_cnt [8];
    bit m_err;
    bit armed = 1'b0;
    int t = 0;
    int last_deq = -100;

    port_wr_enqueue #(.CNT_W(CNT_W), .UPD_GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_prior(enq_prior), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_prior(deq_prior), .deq_ready(deq_ready),
        .queue_empty(queue_empty), .queue_full(queue_full),
        .update(update), .total_cnt(total_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    endtask

    function automatic int m_sum();
        int s = 0;
        for (int i = 0; i < 8; i++) s += m_cnt[i];
        return s;
    endfunction

    // compare every output with the model; deq_ready/update follow from the last legal dequeue time
    task automatic check_all();
        logic [7:0] e_emp, e_full;
        for (int i = 0; i < 8; i++) begin
            e_emp[i]  = m_cnt[i] == 0;
            e_full[i] = m_cnt[i] == MAX;
        end
        chk("queue_empty", 32'(queue_empty), 32'(e_emp));
        chk("queue_full", 32'(queue_full), 32'(e_full));
        chk("enq_ready", 32'(enq_ready), 32'(m_cnt[enq_prior] != MAX));
        chk("deq_ready", 32'(deq_ready), 32'(t > last_deq + GAP));
        chk("update", 32'(update), 32'(t == last_deq + 1));
        chk("total_cnt", 32'(total_cnt), 32'(m_sum()));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic model_step();
        bit e_acc, d_acc, legal;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            m_err = 1'b0;
            last_deq = -100;
            armed = 1'b1;
        end else begin
            e_acc = enq_valid && m_cnt[enq_prior] != MAX;
            d_acc = deq_valid && t > last_deq + GAP;
            legal = d_acc && deq_prior < 8 && m_cnt[deq_prior[2:0]] != 0;
            if (d_acc && !legal) m_err = 1'b1;
            if (e_acc) m_cnt[enq_prior]++;
            if (legal) begin
                m_cnt[deq_prior[2:0]]--;
                last_deq = t;
            end
        end
        t++;
    endtask

    task automatic cyc(input logic r, input logic ev, input logic [2:0] ep, input logic dv, input logic [3:0] dp);
        @(negedge clk);
        rst_n = r;
        enq_valid = ev;
        enq_prior = ep;
        deq_valid = dv;
        deq_prior = dp;
        #1;
        if (armed) check_all();
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'd0, 1'b0, 4'd8);
    endtask

    initial begin
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 4'd8);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 4'd8);
        #1;
        chk("rst_empty", 32'(queue_empty), 32'hFF);
        chk("rst_full", 32'(queue_full), 32'h00);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_deq_ready", 32'(deq_ready), 32'd1);
        chk("rst_update", 32'(update), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_total", 32'(total_cnt), 32'd0);

        cyc(1'b1, 1'b1, 3'd3, 1'b0, 4'd8);
        #1 chk("enq3_empty", 32'(queue_empty), 32'hF7);
        cyc(1'b1, 1'b1, 3'd3, 1'b0, 4'd8);
        #1 chk("enq3_total", 32'(total_cnt), 32'd2);
        cyc(1'b1, 1'b0, 3'd0, 1'b1, 4'd3);
        #1 chk("deq3_update", 32'(update), 32'd1);
        chk("deq3_ready_lo", 32'(deq_ready), 32'd0);
        idle(5);
        #1 chk("hold_last_ready", 32'(deq_ready), 32'd0);
        chk("hold_update", 32'(update), 32'd0);
        idle(1);
        #1 chk("hold_done_ready", 32'(deq_ready), 32'd1);
        cyc(1'b1, 1'b0, 3'd0, 1'b1, 4'd3);
        #1 chk("deq3b_empty", 32'(queue_empty), 32'hFF);
        idle(GAP);

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 3'd0, 1'b0, 4'd8);
        #1 chk("full0", 32'(queue_full[0]), 32'd1);
        chk("full0_enq_ready", 32'(enq_ready), 32'd0);
        enq_prior = 3'd5;
        #1 chk("prio5_enq_ready", 32'(enq_ready), 32'd1);
        cyc(1'b1, 1'b1, 3'd0, 1'b0, 4'd8);
        #1 chk("full0_total", 32'(total_cnt), 32'd3);

        cyc(1'b1, 1'b1, 3'd2, 1'b0, 4'd8);
        cyc(1'b1, 1'b1, 3'd2, 1'b1, 4'd2);
        #1 chk("sim_update", 32'(update), 32'd1);
        chk("sim_total", 32'(total_cnt), 32'd4);
        chk("sim_empty2", 32'(queue_empty[2]), 32'd0);
        idle(GAP);

        cyc(1'b1, 1'b0, 3'd0, 1'b1, 4'd4);
        #1 chk("ill4_update", 32'(update), 32'd0);
        chk("ill4_err", 32'(err), 32'd1);
        chk("ill4_ready", 32'(deq_ready), 32'd1);
        cyc(1'b1, 1'b0, 3'd0, 1'b1, 4'd8);
        #1 chk("ill8_update", 32'(update), 32'd0);
        chk("ill8_err", 32'(err), 32'd1);
        chk("ill8_total", 32'(total_cnt), 32'd4);

        cyc(1'b1, 1'b0, 3'd0, 1'b1, 4'd0);
        idle(2);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 4'd8);
        #1 chk("rsthold_ready", 32'(deq_ready), 32'd1);
        chk("rsthold_empty", 32'(queue_empty), 32'hFF);
        chk("rsthold_err", 32'(err), 32'd0);

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 2) != 0, 4'($urandom_range(0, 9)));
        @(negedge clk);
        #1 check_all();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/port_wr_enqueue.md
# port_wr_enqueue

Write-side queue-state keeper for one output port. It counts the packets enqueued into the port's 8 priority queues by the write path and the packets retired by the read path. It drives the `queue_empty` vector and the `update` pulse that the port's WRR read dispatcher consumes, and enforces a hold-off window so the dispatcher finishes its mask/round update sequence before the next retirement is accepted.

## Interface
- `CNT_W`, default 8: per-queue packet counter width; capacity per queue is 2^CNT_W-1.
- `UPD_GAP`, default 6: cycles `deq_ready` stays low after an `update` pulse, covering the dispatcher's update sequence.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `enq_valid` input, 1 bit: the write path offers one packet for a queue.
- `enq_prior` input, 3 bits: target priority queue; 0 is the highest priority.
- `enq_ready` output, 1 bit: the enqueue is accepted when both `enq_valid` and `enq_ready` are high.
- `deq_valid` input, 1 bit: the read path finished reading one packet.
- `deq_prior` input, 4 bits: the queue that was read; this is the dispatcher's `rd_prior`, and value 8 means "none".
- `deq_ready` output, 1 bit: the dequeue is accepted when both `deq_valid` and `deq_ready` are high.
- `queue_empty` output, 8 bits: bit i is 1 when queue i holds 0 packets.
- `queue_full` output, 8 bits: bit i is 1 when queue i holds 2^CNT_W-1 packets.
- `update` output, 1 bit: one-cycle pulse to the dispatcher after each accepted dequeue.
- `total_cnt` output, CNT_W+3 bits: sum of all eight counters.
- `err` output, 1 bit: sticky flag for an illegal dequeue.

## Operation
- Eight registered counters `cnt[i]`, each CNT_W bits wide.
  - `queue_empty[i]` is driven combinationally as `cnt[i]==0`.
  - `queue_full[i]` is driven combinationally as `cnt[i]` all ones.
- `enq_ready` is driven combinationally as `~queue_full[enq_prior]`.
- An accepted enqueue increments `cnt[enq_prior]` at the clock edge.
- An accepted dequeue decrements `cnt[deq_prior]` at the clock edge.
- If an enqueue and a dequeue hit the same queue in one cycle, that counter is unchanged. Each is still counted as accepted, and `update` still fires.
- A dequeue is illegal when `deq_prior`>=8 or `cnt[deq_prior]`==0. An illegal dequeue:
  - is still handshaken (consumed);
  - leaves every counter unchanged;
  - sets `err` to 1, where it stays until reset;
  - produces no `update`.
- `total_cnt` is a register, changed by +1, -1 or 0 in the same cycle as the counters. It always equals the sum of `cnt[i]`.
- FSM with states IDLE, UPD, HOLD:
  - IDLE: `deq_ready`=1. A legal accepted dequeue moves the FSM to UPD.
  - UPD: lasts exactly one cycle. `update`=1 and `deq_ready`=0. The hold counter is loaded with UPD_GAP-1, then the FSM moves to HOLD.
  - HOLD: `deq_ready`=0. The hold counter decrements each cycle, and the FSM returns to IDLE when it reaches 0.
  - With UPD_GAP<=1, HOLD is skipped and UPD returns directly to IDLE.
- Enqueues are accepted in every FSM state. Only dequeues are gated.

## Timing
- Reset (`rst_n`=0 sampled at a clock edge):
  - all counters and `total_cnt` = 0;
  - `queue_empty`=8'hFF, `queue_full`=8'h00;
  - `update`=0, `err`=0, FSM=IDLE;
  - `enq_ready`=1, `deq_ready`=1.
- Reset asserted mid-UPD or mid-HOLD returns to IDLE at the next edge, with all counts cleared.
- Enqueue latency: after acceptance at edge N, the new `queue_empty` and `queue_full` values are visible in the cycle following edge N.
- Dequeue to update: after acceptance at edge N, the decremented `queue_empty` and `update`=1 are both visible in cycle N+1. The dispatcher therefore samples the post-dequeue empty vector together with `update`.
- `deq_ready` is back at 1 in cycle N+1+UPD_GAP. The minimum spacing between legal dequeues is UPD_GAP+1 cycles.
- Counter saturation: increments cannot overflow, because `enq_ready` is low when the queue is full. Decrements cannot underflow, because that case is treated as an illegal dequeue.

## Test plan
- **Reset:** drive `rst_n`=0 for 2 cycles -> `queue_empty`=8'hFF, `queue_full`=0, `enq_ready`=1, `deq_ready`=1, `update`=0, `err`=0, `total_cnt`=0.
- **Enqueue/dequeue path:** enqueue prio 3 twice, then dequeue prio 3 -> `queue_empty`=8'hF7 after the first enqueue and `total_cnt`=2. After the dequeue, `update` pulses exactly 1 cycle and `deq_ready` stays low for 6 cycles. After a second dequeue, `queue_empty`=8'hFF.
- **Full queue (CNT_W=2):** enqueue prio 0 three times -> `queue_full[0]`=1 and `enq_ready`=0 for prio 0. `enq_ready`=1 for prio 5. A fourth `enq_valid` leaves `cnt[0]`=3.
- **Simultaneous events:** enqueue prio 2 and dequeue prio 2 in the same cycle with `cnt[2]`=1 -> `cnt[2]` stays 1, `update`=1, `total_cnt` is unchanged.
- **Illegal dequeues:** dequeue prio 4 when it is empty, then dequeue `deq_prior`=8 -> no `update` pulse, counters unchanged, `err`=1 and sticky, FSM stays IDLE.
- **Reset mid-HOLD:** assert reset 2 cycles after an `update` -> next cycle `deq_ready`=1, `queue_empty`=8'hFF, `err`=0.
